// File: rtl/spec_fifo_ckpt_if.sv
// Handshake bundle for spec_fifo_ckpt: speculative write side, committed read side, occupancy.
// With SPEC_FIFO_CKPT_ERR_EN defined the bundle also carries the sticky err flag.
interface spec_fifo_ckpt_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CKPTS = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int CK_W  = $clog2(CKPTS) + 1;

    logic             commit;
    logic             revert;
    logic             mark;
    logic             ready_in;
    logic             valid_in;
    logic [WIDTH-1:0] data_in;
    logic             ready_out;
    logic             valid_out;
    logic [WIDTH-1:0] data_out;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] spec_count;
    logic [CK_W-1:0]  ckpt_count;
`ifdef SPEC_FIFO_CKPT_ERR_EN
    logic             err;
`endif

    modport master (
        output commit, revert, mark, valid_in, data_in, ready_out,
        input  ready_in, valid_out, data_out, count, spec_count, ckpt_count
`ifdef SPEC_FIFO_CKPT_ERR_EN
        , input err
`endif
    );

    modport slave (
        input  commit, revert, mark, valid_in, data_in, ready_out,
        output ready_in, valid_out, data_out, count, spec_count, ckpt_count
`ifdef SPEC_FIFO_CKPT_ERR_EN
        , output err
`endif
    );
endinterface

// File: rtl/spec_fifo_ckpt.sv
// Speculative FIFO with a CKPTS-deep stack of nested rollback checkpoints.
// Optional feature macro SPEC_FIFO_CKPT_ERR_EN adds a sticky protocol-error flag.
module spec_fifo_ckpt #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CKPTS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    spec_fifo_ckpt_if.slave     bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int CW  = $clog2(CKPTS) + 1;
    localparam int CIW = (CKPTS > 1) ? $clog2(CKPTS) : 1;
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [CW-1:0] CKPTS_C = CW'(CKPTS);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    stack_q [CKPTS];

    logic [PW-1:0]  rd_q, rd_d;
    logic [PW-1:0]  wr_q, wr_d;
    logic [PW-1:0]  spec_q, spec_d;
    logic [CW-1:0]  ckpt_q, ckpt_d;

    logic [PW-1:0]  count_w, spec_count_w;
    logic           full, wr_en, rd_en, push, ovf;
    logic [CIW-1:0] push_idx, pop_idx;

    assign count_w      = wr_q - rd_q;
    assign spec_count_w = spec_q - rd_q;
    assign full         = (spec_count_w == DEPTH_C);
    assign wr_en        = bus.valid_in & ~full;
    assign rd_en        = bus.ready_out & (count_w != '0);
    assign push_idx     = ckpt_q[CIW-1:0];
    assign pop_idx      = push_idx - CIW'(1);

    assign bus.ready_in   = ~full;
    assign bus.valid_out  = (count_w != '0);
    assign bus.data_out   = mem_q[rd_q[AW-1:0]];
    assign bus.count      = count_w;
    assign bus.spec_count = spec_count_w;
    assign bus.ckpt_count = ckpt_q;

    // revert beats commit beats mark; reads advance independently of all three
    always_comb begin
        rd_d   = rd_q + PW'(rd_en);
        wr_d   = wr_q;
        spec_d = spec_q + PW'(wr_en);
        ckpt_d = ckpt_q;
        push   = 1'b0;
        ovf    = 1'b0;
        if (bus.revert) begin
            if (ckpt_q != '0) begin
                spec_d = stack_q[pop_idx];
                ckpt_d = ckpt_q - CW'(1);
            end else begin
                spec_d = wr_q;
            end
        end else if (bus.commit) begin
            wr_d   = spec_q + PW'(wr_en);
            ckpt_d = '0;
        end else if (bus.mark) begin
            if (ckpt_q != CKPTS_C) begin
                push   = 1'b1;
                ckpt_d = ckpt_q + CW'(1);
            end else begin
                ovf = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q   <= '0;
            wr_q   <= '0;
            spec_q <= '0;
            ckpt_q <= '0;
            for (int i = 0; i < CKPTS; i++) stack_q[i] <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            spec_q <= spec_d;
            ckpt_q <= ckpt_d;
            // the checkpoint records the pointer before this cycle's write
            if (push) stack_q[push_idx] <= spec_q;
        end
    end

    // Storage is not reset; a write during revert lands in a slot past spec_wr_ptr and is dead.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[spec_q[AW-1:0]] <= bus.data_in;
    end

`ifdef SPEC_FIFO_CKPT_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | ovf | (bus.valid_in & full) | (bus.ready_out & (count_w == '0));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err_q <= 1'b0;
        else          err_q <= err_d;
    end

    assign bus.err = err_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf;
`endif
endmodule
